ps2_kbd_tx: RTL and testbench

PS/2 device-side transmitter: the keyboard end of the ps2_kbd_clk/ps2_kbd_data link that the motherboard keyboard decoder receives. It accepts scancode bytes from the IO controller over a valid/ready byte stream and buffers them in a small FIFO. It serialises each byte as an 11-bit PS/2 frame with a self-generated clock. It sits in the clk_sys domain between the SPI IO block and the motherboard keyboard input, and honours host inhibit by aborting the frame and retransmitting it.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_kbd_tx_if.sv | 21 ++
 rtl/ps2_fifo.sv | 58 +++++
 rtl/ps2_kbd_tx.sv | 139 +++++++++++++
 tb/tb_ps2_kbd_tx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard-side transmitter.
// Frame layout: start 0, data LSB first, odd parity, stop 1.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam int STOP_IDX   = 10;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

  // bit 0 is the first bit on the wire
  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [7:0] d
  );
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Scancode byte stream into the PS/2 transmitter.
// A byte moves when din_valid and din_ready are both high.
interface ps2_kbd_tx_if;

  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/ps2_fifo.sv
// Synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap for free.
module ps2_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + 1'b1;
      end
      if (do_pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: buffers scancodes and clocks them
// out as 11-bit frames; host inhibit aborts and retransmits.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4480,
  parameter int GAP_CYCLES  = 8960,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  ps2_kbd_tx_if.slave                  bus,
  input  logic                         inhibit,
  output logic                         ps2_clk,
  output logic                         ps2_data,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int HW = $clog2(HALF_PERIOD);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] H_LOAD = HW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] G_LOAD = GW'(GAP_CYCLES - 1);

  state_t                  state;
  logic [HW-1:0]           hcnt;
  logic [GW-1:0]           gcnt;
  logic [3:0]              idx;
  logic [FRAME_BITS-1:0]   shreg;
  logic [7:0]              head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    last_cyc;
  logic                    at_stop;
  logic                    stop_end;

  assign bus.din_ready = ~full;
  assign push          = bus.din_valid & bus.din_ready;
  assign last_cyc      = (hcnt == '0);
  assign at_stop       = (idx == 4'(STOP_IDX));
  assign stop_end      = (state == LOW) & at_stop & last_cyc;
  assign pop           = stop_end;

  ps2_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .wdata (bus.din),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      gcnt     <= '0;
      idx      <= '0;
      shreg    <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (!empty && !inhibit) begin
            shreg    <= make_frame(head);
            idx      <= '0;
            hcnt     <= H_LOAD;
            ps2_data <= 1'b0;
            busy     <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (inhibit) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            gcnt     <= G_LOAD;
            state    <= GAP;
          end else if (last_cyc) begin
            ps2_clk <= 1'b0;
            hcnt    <= H_LOAD;
            state   <= LOW;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        LOW: begin
          // the final cycle of the stop bit commits the frame
          if (inhibit && !stop_end) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            gcnt     <= G_LOAD;
            state    <= GAP;
          end else if (last_cyc) begin
            ps2_clk <= 1'b1;
            if (at_stop) begin
              ps2_data <= 1'b1;
              gcnt     <= G_LOAD;
              state    <= GAP;
            end else begin
              idx      <= idx + 1'b1;
              shreg    <= shreg >> 1;
              ps2_data <= shreg[1];
              hcnt     <= H_LOAD;
              state    <= HIGH;
            end
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        GAP: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (inhibit) begin
            gcnt <= G_LOAD;
          end else if (gcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: decodes the PS/2 lines at each falling
// edge and compares frames against bytes pushed.
module tb_ps2_kbd_tx;

  localparam int HP    = 4;
  localparam int GAP   = 8;
  localparam int DEPTH = 8;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       inhibit = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [3:0] fifo_count;

  ps2_kbd_tx_if bus();

  ps2_kbd_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus.slave),
    .inhibit    (inhibit),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [10:0] rxq [$];
  logic [10:0] cur;
  int          nbits    = 0;
  int          high_run = 0;
  logic        prev_clk = 1'b1;
  logic [7:0]  fbytes [9];

  // line decoder: a frame is 11 bits taken at falling edges;
  // a high stretch longer than a half period restarts it
  always @(negedge clk_sys) begin
    if (reset) begin
      nbits    = 0;
      high_run = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        cur[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          rxq.push_back(cur);
          nbits = 0;
        end
      end
      if (ps2_clk) high_run++;
      else         high_run = 0;
      if (high_run > HP) nbits = 0;
      prev_clk = ps2_clk;
    end
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.din       = d;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (rxq.size() < n) begin
      n_fail++;
      $display("FAIL frame_wait: got %0d frames, need %0d", rxq.size(), n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      step();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: busy=%b, need 0", busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp += 5;
    if (ps2_clk !== 1'b1) begin
      n_fail++; $display("FAIL %s ps2_clk: got %b, need 1", tag, ps2_clk);
    end
    if (ps2_data !== 1'b1) begin
      n_fail++; $display("FAIL %s ps2_data: got %b, need 1", tag, ps2_data);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: got %b, need 0", tag, busy);
    end
    if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL %s count: got %0d, need 0", tag, fifo_count);
    end
    if (bus.din_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s din_ready: got %b, need 1", tag, bus.din_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();
    check_reset_outputs("post_reset");
  endtask

  task automatic test_single();
    int nb = 0;
    int k  = 0;
    rxq.delete();
    push_byte(8'h1C);
    n_cmp++;
    if (fifo_count !== 4'd1) begin
      n_fail++; $display("FAIL single_count: got %0d, need 1", fifo_count);
    end
    while (busy !== 1'b1 && k < 10) begin step(); k++; end
    while (busy === 1'b1 && nb < 1000) begin nb++; step(); end
    n_cmp++;
    if (nb != 22 * HP + GAP) begin
      n_fail++; $display("FAIL single_len: got %0d cycles, need %0d", nb, 22 * HP + GAP);
    end
    n_cmp++;
    if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL single_pop: count %0d, need 0", fifo_count);
    end
    wait_frames(1, 10);
    if (rxq.size() >= 1) begin
      n_cmp += 2;
      if (rxq[0] !== 11'b10000111000) begin
        n_fail++; $display("FAIL single_bits: got %b, need 10000111000", rxq[0]);
      end
      if (rxq[0] !== exp_frame(8'h1C)) begin
        n_fail++; $display("FAIL single_model: got %b, need %b", rxq[0], exp_frame(8'h1C));
      end
    end
  endtask

  task automatic test_back_to_back();
    int k  = 0;
    int ng = 0;
    int ni = 0;
    bit hi_bad = 0;
    wait_idle();
    rxq.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(1, 200);
    while (ps2_clk === 1'b0 && k < 100) begin step(); k++; end
    while (busy === 1'b1 && ng < 100) begin
      if (!(ps2_clk === 1'b1 && ps2_data === 1'b1)) hi_bad = 1;
      ng++;
      step();
    end
    while (busy === 1'b0 && ni < 100) begin ni++; step(); end
    n_cmp += 4;
    if (ng != GAP) begin
      n_fail++; $display("FAIL b2b_gap: got %0d, need %0d", ng, GAP);
    end
    if (hi_bad) begin
      n_fail++; $display("FAIL b2b_gap_lines: got low line, need both high");
    end
    if (ni != 1) begin
      n_fail++; $display("FAIL b2b_idle: got %0d, need 1", ni);
    end
    if (ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin
      n_fail++; $display("FAIL b2b_start: got clk=%b data=%b, need 1/0", ps2_clk, ps2_data);
    end
    wait_frames(2, 200);
    if (rxq.size() >= 2) begin
      n_cmp += 2;
      if (rxq[0] !== exp_frame(8'h00) || rxq[0][9] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_f0: got %b, need %b", rxq[0], exp_frame(8'h00));
      end
      if (rxq[1] !== exp_frame(8'hFF) || rxq[1][9] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_f1: got %b, need %b", rxq[1], exp_frame(8'hFF));
      end
    end
  endtask

  task automatic test_inhibit();
    int k  = 0;
    int nr = 0;
    bit bad = 0;
    wait_idle();
    rxq.delete();
    push_byte(8'h1C);
    while (nbits < 6 && k < 300) begin step(); k++; end
    inhibit = 1'b1;
    step();
    n_cmp += 2;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      n_fail++; $display("FAIL inh_abort: got clk=%b data=%b, need 1/1", ps2_clk, ps2_data);
    end
    if (fifo_count !== 4'd1) begin
      n_fail++; $display("FAIL inh_nopop: count %0d, need 1", fifo_count);
    end
    repeat (19) begin
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b1) bad = 1;
      step();
    end
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL inh_hold: got line low or busy low, need high");
    end
    inhibit = 1'b0;
    while (busy === 1'b1 && nr < 100) begin step(); nr++; end
    n_cmp++;
    if (nr != GAP) begin
      n_fail++; $display("FAIL inh_release: got %0d cycles, need %0d", nr, GAP);
    end
    wait_frames(1, 200);
    wait_idle();
    n_cmp += 3;
    if (rxq.size() != 1) begin
      n_fail++; $display("FAIL inh_frames: got %0d, need 1", rxq.size());
    end
    if (rxq.size() >= 1 && rxq[0] !== exp_frame(8'h1C)) begin
      n_fail++; $display("FAIL inh_resend: got %b, need %b", rxq[0], exp_frame(8'h1C));
    end
    if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL inh_count: got %0d, need 0", fifo_count);
    end
  endtask

  task automatic test_fifo_full();
    wait_idle();
    inhibit = 1'b1;
    for (int i = 0; i < 9; i++) fbytes[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      bus.din       = fbytes[i];
      bus.din_valid = 1'b1;
      n_cmp++;
      if (bus.din_ready !== (i < DEPTH)) begin
        n_fail++; $display("FAIL full_ready[%0d]: got %b, need %b", i, bus.din_ready, i < DEPTH);
      end
      step();
    end
    bus.din_valid = 1'b0;
    n_cmp += 3;
    if (fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL full_count: got %0d, need 8", fifo_count);
    end
    if (bus.din_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b, need 0", bus.din_ready);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL full_busy: got %b, need 0", busy);
    end
  endtask

  task automatic test_full_pop();
    int k = 0;
    bit bad = 0;
    rxq.delete();
    inhibit = 1'b0;
    wait_frames(1, 200);
    bus.din       = 8'h5A;
    bus.din_valid = 1'b1;
    while (fifo_count === 4'd8 && k < 100) begin
      if (bus.din_ready !== 1'b0) bad = 1;
      step();
      k++;
    end
    n_cmp += 4;
    if (bad) begin
      n_fail++; $display("FAIL pop_ready: got 1 while full, need 0");
    end
    if (k != HP) begin
      n_fail++; $display("FAIL pop_time: got %0d cycles, need %0d", k, HP);
    end
    if (fifo_count !== 4'd7) begin
      n_fail++; $display("FAIL pop_count: got %0d, need 7", fifo_count);
    end
    if (bus.din_ready !== 1'b1) begin
      n_fail++; $display("FAIL pop_ready_after: got %b, need 1", bus.din_ready);
    end
    bus.din_valid = 1'b0;
    wait_frames(8, 1200);
    wait_idle();
    n_cmp += 2;
    if (rxq.size() != 8) begin
      n_fail++; $display("FAIL pop_nframes: got %0d, need 8", rxq.size());
    end
    if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL pop_drain: got %0d, need 0", fifo_count);
    end
    for (int i = 0; i < 8 && i < rxq.size(); i++) begin
      n_cmp++;
      if (rxq[i] !== exp_frame(fbytes[i])) begin
        n_fail++; $display("FAIL order[%0d]: got %b, need %b", i, rxq[i], exp_frame(fbytes[i]));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int k = 0;
    wait_idle();
    inhibit = 1'b1;
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    inhibit = 1'b0;
    rxq.delete();
    while (nbits < 4 && k < 300) begin step(); k++; end
    reset = 1'b1;
    step();
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (150) step();
    n_cmp += 2;
    if (rxq.size() != 0) begin
      n_fail++; $display("FAIL midreset_frames: got %0d, need 0", rxq.size());
    end
    if (busy !== 1'b0 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL midreset_quiet: got busy=%b count=%0d, need 0/0", busy, fifo_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] expq [$];
    int pushed = 0;
    wait_idle();
    rxq.delete();
    for (int i = 0; i < 20; i++) begin
      int k = 0;
      while (pushed - rxq.size() >= 5 && k < 2000) begin step(); k++; end
      repeat ($urandom_range(0, 20)) step();
      bus.din       = 8'($urandom);
      bus.din_valid = 1'b1;
      n_cmp++;
      if (bus.din_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b, need 1", i, bus.din_ready);
      end
      expq.push_back(bus.din);
      pushed++;
      step();
      bus.din_valid = 1'b0;
    end
    wait_frames(20, 4000);
    for (int i = 0; i < 20 && i < rxq.size(); i++) begin
      n_cmp++;
      if (rxq[i] !== exp_frame(expq[i])) begin
        n_fail++; $display("FAIL rnd_frame[%0d]: got %b, need %b", i, rxq[i], exp_frame(expq[i]));
      end
    end
  endtask

  initial begin
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_inhibit();
    test_fifo_full();
    test_full_pop();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
